// File: rtl/keycode_event_tracker.sv
// Diffs successive HID boot reports into press/release events queued in a FWFT FIFO.
// Optional auto-repeat events are enabled by defining KEYCODE_REPEAT_EN.
module keycode_event_tracker #(
  parameter int unsigned NUM_KEYS      = 6,
  parameter int unsigned KEY_W         = 8,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned REPEAT_DELAY  = 500000,
  parameter int unsigned REPEAT_PERIOD = 50000
) (
  input  logic                      clk_clk,
  input  logic                      reset_reset,
  input  logic [NUM_KEYS*KEY_W-1:0] report_data,
  input  logic                      report_valid,
  output logic                      report_ready,
  output logic [KEY_W+1:0]          evt_data,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [$clog2(DEPTH):0]    evt_count,
  output logic [KEY_W-1:0]          last_key
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned IdxW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int unsigned RptW = NUM_KEYS * KEY_W;

  typedef enum logic [1:0] {StIdle, StRel, StPrs, StCommit} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [RptW-1:0]   new_q, new_d;
  logic [RptW-1:0]   prev_q, prev_d;
  logic [KEY_W-1:0]  last_key_q, last_key_d;

  logic [KEY_W-1:0]  cur_key;
  logic              in_other, dup, emit;
  logic              scan_push, rpt_push, push, pop, full, can_push;
  logic [KEY_W+1:0]  push_data;

  logic [KEY_W+1:0]  mem [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]     count_q;

  // REL scans old slots against the new report; PRS scans new slots against the old one.
  always_comb begin
    cur_key  = '0;
    in_other = 1'b0;
    dup      = 1'b0;
    for (int unsigned j = 0; j < NUM_KEYS; j++) begin
      if (IdxW'(j) == idx_q) begin
        cur_key = (state_q == StPrs) ? new_q[j*KEY_W +: KEY_W] : prev_q[j*KEY_W +: KEY_W];
      end
    end
    for (int unsigned j = 0; j < NUM_KEYS; j++) begin
      if (((state_q == StPrs) ? prev_q[j*KEY_W +: KEY_W] : new_q[j*KEY_W +: KEY_W]) == cur_key) begin
        in_other = 1'b1;
      end
      if (IdxW'(j) < idx_q &&
          ((state_q == StPrs) ? new_q[j*KEY_W +: KEY_W] : prev_q[j*KEY_W +: KEY_W]) == cur_key) begin
        dup = 1'b1;
      end
    end
    emit = (state_q == StRel || state_q == StPrs) && cur_key != '0 && !in_other && !dup;
  end

  assign full     = count_q == (PtrW+1)'(DEPTH);
  assign pop      = evt_ready && count_q != '0;
  assign can_push = !full || pop;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    new_d      = new_q;
    prev_d     = prev_q;
    last_key_d = last_key_q;
    scan_push  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (report_valid) begin
          new_d   = report_data;
          idx_d   = '0;
          state_d = StRel;
        end
      end
      StRel, StPrs: begin
        // A due emission with no room holds the slot index until space frees up.
        if (!emit || can_push) begin
          scan_push = emit;
          if (emit) begin
            if (state_q == StPrs) begin
              last_key_d = cur_key;
            end else if (cur_key == last_key_q) begin
              last_key_d = '0;
            end
          end
          if (idx_q == IdxW'(NUM_KEYS - 1)) begin
            idx_d   = '0;
            state_d = (state_q == StRel) ? StPrs : StCommit;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      StCommit: begin
        prev_d  = new_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      new_q      <= '0;
      prev_q     <= '0;
      last_key_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      new_q      <= new_d;
      prev_q     <= prev_d;
      last_key_q <= last_key_d;
    end
  end

`ifdef KEYCODE_REPEAT_EN
  logic [31:0] rpt_cnt_q, rpt_cnt_d;
  logic        rpt_first_q, rpt_first_d;
  logic        rpt_due;

  always_comb begin
    rpt_cnt_d   = rpt_cnt_q + 32'd1;
    rpt_first_d = rpt_first_q;
    rpt_due     = 1'b0;
    if (last_key_q == '0 || last_key_d != last_key_q) begin
      rpt_cnt_d   = '0;
      rpt_first_d = 1'b1;
    end else if (rpt_cnt_q == (rpt_first_q ? REPEAT_DELAY - 1 : REPEAT_PERIOD - 1)) begin
      // Fires whether or not the push lands; a dropped repeat still restarts the period.
      rpt_due     = 1'b1;
      rpt_cnt_d   = '0;
      rpt_first_d = 1'b0;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b1;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_first_q <= rpt_first_d;
    end
  end

  assign rpt_push = rpt_due && state_q == StIdle && !full;
`else
  logic unused_rpt_params;
  assign unused_rpt_params = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign rpt_push          = 1'b0;
`endif

  assign push      = scan_push || rpt_push;
  assign push_data = scan_push ? {((state_q == StPrs) ? 2'b01 : 2'b10), cur_key}
                               : {2'b11, last_key_q};

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop) begin
        count_q <= count_q + (PtrW+1)'(1);
      end else if (!push && pop) begin
        count_q <= count_q - (PtrW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (push) mem[wr_ptr_q] <= push_data;
  end

  assign report_ready = state_q == StIdle;
  assign evt_data     = mem[rd_ptr_q];
  assign evt_valid    = count_q != '0;
  assign evt_count    = count_q;
  assign last_key     = last_key_q;

endmodule

// File: tb/tb_keycode_event_tracker.sv
// Self-checking bench for keycode_event_tracker: directed cases plus random reports
// checked against a set-difference reference model.
module tb_keycode_event_tracker;

  localparam int NK = 6;
  localparam int KW = 8;
  localparam int DP = 4;

  logic              clk_clk = 1'b0;
  logic              reset_reset = 1'b1;
  logic [NK*KW-1:0]  report_data = '0;
  logic              report_valid = 1'b0;
  logic              report_ready;
  logic [KW+1:0]     evt_data;
  logic              evt_valid;
  logic              evt_ready = 1'b1;
  logic [$clog2(DP):0] evt_count;
  logic [KW-1:0]     last_key;

  always #5 clk_clk = ~clk_clk;

  keycode_event_tracker #(
    .NUM_KEYS(NK), .KEY_W(KW), .DEPTH(DP), .REPEAT_DELAY(10), .REPEAT_PERIOD(4)
  ) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .report_data(report_data),
    .report_valid(report_valid), .report_ready(report_ready), .evt_data(evt_data),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_count(evt_count), .last_key(last_key)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rpt_seen = 0;
  logic [KW+1:0] got[$];
  logic [KW+1:0] exp_q[$];
  int got_cyc[$];
  int rpt_cyc[$];
  logic [KW-1:0] prev_m[NK];
  logic [KW-1:0] last_m;
  bit rnd_ready = 1'b0;

  always @(posedge clk_clk) cyc <= cyc + 1;

  // Record each head that will be popped at the coming rising edge.
  always @(negedge clk_clk) begin
    if (!reset_reset && evt_valid && evt_ready) begin
      if (evt_data[KW+1:KW] == 2'b11) begin
        rpt_seen <= rpt_seen + 1;
        rpt_cyc.push_back(cyc);
      end else begin
        got.push_back(evt_data);
        got_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk_clk);
    #1;
    if (rnd_ready) evt_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [KW-1:0] slot(input logic [NK*KW-1:0] r, input int i);
    return r[i*KW +: KW];
  endfunction

  // Releases: old keys gone from the new report; presses: new keys not in the old one.
  function automatic void model_report(input logic [NK*KW-1:0] rpt);
    logic [KW-1:0] seen[$];
    logic [KW-1:0] k;
    seen.delete();
    for (int i = 0; i < NK; i++) begin
      k = prev_m[i];
      if (k != 0 && !(k inside {seen})) begin
        bit present = 1'b0;
        for (int j = 0; j < NK; j++) if (slot(rpt, j) == k) present = 1'b1;
        if (!present) begin
          exp_q.push_back({2'b10, k});
          if (last_m == k) last_m = '0;
        end
      end
      seen.push_back(k);
    end
    seen.delete();
    for (int i = 0; i < NK; i++) begin
      k = slot(rpt, i);
      if (k != 0 && !(k inside {seen}) && !(k inside {prev_m})) begin
        exp_q.push_back({2'b01, k});
        last_m = k;
      end
      seen.push_back(k);
    end
    for (int i = 0; i < NK; i++) prev_m[i] = slot(rpt, i);
  endfunction

  task automatic send_report(input logic [NK*KW-1:0] rpt, output int lat);
    int n = 0;
    while (!report_ready && n < 300) begin tick(); n++; end
    chk("ready_before_send", 32'(report_ready), 1);
    report_data  = rpt;
    report_valid = 1'b1;
    tick();
    report_valid = 1'b0;
    lat = 1;
    while (!report_ready && lat < 400) begin tick(); lat++; end
    chk("ready_after_scan", 32'(report_ready), 1);
  endtask

  task automatic drain_cmp(input string tag);
    int n = 0;
    while (evt_count != 0 && n < 500) begin tick(); n++; end
    chk({tag, "_drained"}, 32'(evt_count), 0);
    chk({tag, "_num_events"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s_evt%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
    end
    chk({tag, "_last_key"}, 32'(last_key), 32'(last_m));
    got.delete();
    exp_q.delete();
  endtask

  task automatic reset_model();
    for (int i = 0; i < NK; i++) prev_m[i] = '0;
    last_m = '0;
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    int lat;
    int n;
    logic [NK*KW-1:0] r;
    reset_model();
    tick();
    tick();
    reset_reset = 1'b0;
    chk("rst_ready", 32'(report_ready), 1);
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_count", 32'(evt_count), 0);
    chk("rst_last", 32'(last_key), 0);

    // Single press; no stalls so the scan takes 2*NUM_KEYS+2 cycles.
    r = 48'h0000_0000_001D;
    model_report(r);
    send_report(r, lat);
    chk("t1_latency", lat, 14);
    drain_cmp("t1");
    chk("t1_last_const", 32'(last_key), 32'h1D);

    r = 48'h0000_0000_1D1B;
    model_report(r);
    send_report(r, lat);
    drain_cmp("t2a");
    r = 48'h0000_0000_1B06;
    model_report(r);
    send_report(r, lat);
    drain_cmp("t2b");
    chk("t2_last_const", 32'(last_key), 32'h06);

    // Identical report: no events and unchanged scan time.
    model_report(r);
    send_report(r, lat);
    chk("ident_latency", lat, 14);
    drain_cmp("ident");

    r = '0;
    model_report(r);
    send_report(r, lat);
    drain_cmp("t3_clear");

    // Back-pressure: FIFO fills, scanner stalls, then all six presses arrive in order.
    evt_ready = 1'b0;
    r = 48'h0A09_0807_0504;
    model_report(r);
    report_data  = r;
    report_valid = 1'b1;
    tick();
    report_valid = 1'b0;
    repeat (20) tick();
    chk("t3_full_count", 32'(evt_count), DP);
    chk("t3_stalled", 32'(report_ready), 0);
    chk("t3_valid", 32'(evt_valid), 1);
    evt_ready = 1'b1;
    n = 0;
    while (!report_ready && n < 100) begin tick(); n++; end
    chk("t3_ready_back", 32'(report_ready), 1);
    drain_cmp("t3");

    r = '0;
    model_report(r);
    send_report(r, lat);
    drain_cmp("t4_clear");
    r = 48'h0000_0000_0404;
    model_report(r);
    send_report(r, lat);
    drain_cmp("t4_dup_press");
    r = '0;
    model_report(r);
    send_report(r, lat);
    drain_cmp("t4_release");
    chk("t4_last_zero", 32'(last_key), 0);

    // Reset in the middle of PRS with three presses queued.
    evt_ready = 1'b0;
    report_data  = 48'h0A09_0807_0504;
    report_valid = 1'b1;
    tick();
    report_valid = 1'b0;
    n = 0;
    while (evt_count != 3 && n < 50) begin tick(); n++; end
    chk("t5_three_queued", 32'(evt_count), 3);
    reset_reset = 1'b1;
    tick();
    chk("t5_valid", 32'(evt_valid), 0);
    chk("t5_count", 32'(evt_count), 0);
    chk("t5_last", 32'(last_key), 0);
    chk("t5_ready", 32'(report_ready), 1);
    reset_reset = 1'b0;
    evt_ready = 1'b1;
    reset_model();
    r = 48'h0000_0000_0004;
    model_report(r);
    send_report(r, lat);
    drain_cmp("t5_after");

    // Random reports drawn from a small key pool to force overlaps and duplicates.
    rnd_ready = 1'b1;
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < NK; i++) begin
        r[i*KW +: KW] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'(8'h04 + $urandom_range(0, 5));
      end
      model_report(r);
      send_report(r, lat);
      drain_cmp($sformatf("rnd%0d", it));
    end
    rnd_ready = 1'b0;
    evt_ready = 1'b1;

`ifdef KEYCODE_REPEAT_EN
    reset_reset = 1'b1;
    tick();
    reset_reset = 1'b0;
    reset_model();
    got_cyc.delete();
    rpt_cyc.delete();
    r = 48'h0000_0000_001D;
    model_report(r);
    send_report(r, lat);
    repeat (14) tick();
    chk("rp_press_seen", 32'(got_cyc.size()), 1);
    chk("rp_three", 32'(rpt_cyc.size() >= 3), 1);
    if (got_cyc.size() >= 1 && rpt_cyc.size() >= 3) begin
      chk("rp_delay", rpt_cyc[0] - got_cyc[0], 10);
      chk("rp_period1", rpt_cyc[1] - rpt_cyc[0], 4);
      chk("rp_period2", rpt_cyc[2] - rpt_cyc[1], 4);
    end
    drain_cmp("rp_press");
    r = '0;
    model_report(r);
    send_report(r, lat);
    rpt_cyc.delete();
    repeat (40) tick();
    chk("rp_stopped", rpt_cyc.size(), 0);
    drain_cmp("rp_release");
`else
    chk("no_repeat_events", rpt_seen, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
